clk_buff: RTL and testbench
===========================

# clk_buff

Clock buffer that forwards its input clock to an output clock with identical frequency and zero phase offset. It adds reset-sequenced, glitch-free gating and a rising-edge counter for status. It sits at the root of a local clock tree, for example ahead of FIFO/RAM blocks, and all downstream logic runs on `oclk`.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: reset-release synchronizer depth (≥2).
- `CNT_W`, default 16: width of the output edge counter.

Ports, in positional order (this order is fixed; `iclk`, `oclk` first):
- `iclk` input 1: source clock. One clock domain; all sequential logic uses `iclk`.
- `oclk` output 1: buffered, gated clock.
- `irst_n` input 1: reset, asynchronous, active-low.
- `ien` input 1: gate enable, synchronous to `iclk`. 1 means pass the clock.
- `oactive` output 1: 1 while the gate is open.
- `ocnt` output `CNT_W`: count of `oclk` rising edges, wraps modulo 2^`CNT_W`.

## Operation
- Path from `iclk` to `oclk`: `oclk = iclk & gate`. There are no flops, delays, or inversions in this path, so `oclk` rises in the same timestep as `iclk`.
  - Phase difference must be 0.
  - Period difference must be 0.
- `gate` is a level latch, transparent while `iclk` is low and holding while `iclk` is high. Its D input is `ready & en_q`.
- `ready`: the last stage of a `SYNC_STAGES`-deep flop chain.
  - Clocked on `iclk` rising edge.
  - Asynchronously cleared by `irst_n` low.
  - Shifts in a constant 1.
- `en_q`: `ien` registered on `iclk` rising edge; async reset value 0.
- `oactive = gate`.
- `ocnt` increments on each `iclk` rising edge while `gate` is 1.
- Reset values while `irst_n` is 0:
  - `oclk` = 0, `oactive` = 0, `ocnt` = 0, `ready` = 0, `en_q` = 0.
  - `gate` is forced to 0 asynchronously, overriding the latch.

## Timing
- Enable latency: `ien` sampled high at rising edge k makes the gate open in the low phase after edge k. The first `oclk` rise occurs at `iclk` rising edge k+1.
- Disable latency: `ien` sampled low at edge k gives a final full `oclk` pulse at edge k, and `oclk` stays low from edge k+1 onward.
- Reset release: with `irst_n` deasserted in a low phase and `ien` held at 1, the first `oclk` rising edge is `iclk` rising edge `SYNC_STAGES`+1 after release. For the default, that is the 3rd edge.
- Glitch-free gating: `gate` never changes while `iclk` is high. `oclk` pulses are always full `iclk` high phases.
- Reset mid-operation: asserting `irst_n` while `iclk` is high truncates the current `oclk` pulse immediately. This is the only permitted truncated pulse.
- Counter wrap: `ocnt` goes from 2^`CNT_W`−1 to 0 with no flag.
- Simultaneous events: reset dominates enable. `ien` toggling in the same cycle that `ready` rises follows the `en_q & ready` rule above.

## Structure
- Shared package `clk_buff_pkg`: default `SYNC_STAGES` and `CNT_W`, plus a type for the count.
- Sub-module `clk_gate_cell`: latch with async clear, plus the AND that produces `oclk`. It is the only non-flop storage in the block and is isolated for technology mapping, replaceable by a library ICG.
- The top level holds the reset synchronizer, `en_q`, and the counter.

## Test plan
- Period 1.90625 ns `iclk`, reset released, `ien`=1: measure two consecutive rising edges on each of `iclk` and `oclk` → frequency difference 0, phase difference 0.
- Reset release at t=1.5 ns with `ien`=1 → first `oclk` rise coincides with the 3rd `iclk` rise after release. `oactive` goes high in the preceding low phase.
- `ien` dropped for 4 cycles mid-run → `oclk` stays low for exactly 4 `iclk` rising edges, with no runt pulses, and `ocnt` advances by 4 fewer than the total number of `iclk` edges.
- `irst_n` asserted during an `iclk` high phase → `oclk`, `oactive`, and `ocnt` go to 0 in the same timestep. After release, the 3-edge startup repeats.
- `CNT_W`=4, 17 active `oclk` edges → `ocnt` reads 1 after wrapping through 15→0.
- `ien` toggled while `iclk` is high → `gate` changes only after `iclk` falls, with no glitch on `oclk`.

Source files
------------

// File: rtl/clk_buff_pkg.sv
// Shared defaults and types for the clk_buff local clock-root buffer.
`timescale 1ns/1fs
package clk_buff_pkg;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned CNT_W_DEF       = 16;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

endpackage

// File: rtl/clk_gate_cell.sv
// Glitch-free clock gate: low-transparent latch with async clear feeding an AND.
// Kept standalone so it can be swapped for a library ICG cell.
`timescale 1ns/1fs
module clk_gate_cell (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic gclk_o,
  output logic gate_o
);

  logic gate_q;

  // Holding while clk_i is high keeps gclk_o pulses full-width; clear overrides.
  always_latch begin
    if (!rst_ni) begin
      gate_q <= 1'b0;
    end else if (!clk_i) begin
      gate_q <= en_i;
    end
  end

  assign gclk_o = clk_i & gate_q;
  assign gate_o = gate_q;

endmodule

// File: rtl/clk_buff.sv
// Clock buffer: zero-delay gated pass-through of iclk with reset-sequenced
// enable and a rising-edge counter of the gated clock.
`timescale 1ns/1fs
module clk_buff
  import clk_buff_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             iclk,
  output logic             oclk,
  input  logic             irst_n,
  input  logic             ien,
  output logic             oactive,
  output logic [CNT_W-1:0] ocnt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   en_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   ready;
  logic                   gate;
  logic                   gate_en;

  assign sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b1};
  assign ready   = sync_q[SYNC_STAGES-1];
  assign gate_en = ready & en_q;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      sync_q <= '0;
      en_q   <= 1'b0;
    end else begin
      sync_q <= sync_d;
      en_q   <= ien;
    end
  end

  // gate is stable across the rising edge, so it marks exactly the edges that reach oclk.
  always_comb begin
    cnt_d = cnt_q;
    if (gate) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  clk_gate_cell u_gate (
    .clk_i  (iclk),
    .rst_ni (irst_n),
    .en_i   (gate_en),
    .gclk_o (oclk),
    .gate_o (gate)
  );

  assign oactive = gate;
  assign ocnt    = cnt_q;

endmodule

// File: tb/tb_clk_buff.sv
// Self-checking bench for clk_buff: edge-level reference model, directed and random enables.
`timescale 1ns/1fs
module tb_clk_buff;

  localparam real     HALF    = 0.953125;
  localparam longint  HALF_FS = 953125;
  localparam int      SYNC    = 2;

  logic        iclk   = 1'b1;
  logic        irst_n = 1'b0;
  logic        ien    = 1'b1;
  logic        oclk, oactive;
  logic [15:0] ocnt;
  logic        oclk4, oactive4;
  logic [3:0]  ocnt4;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: edges since reset release, gate opened for the
  // coming high phase, ien value to be sampled at the next edge, pulse count.
  int   m_edges = 0;
  logic m_gate  = 1'b0;
  logic m_en    = 1'b1;
  int   m_cnt   = 0;
  int   m_pulses = 0;

  int  n_rise = 0;
  real ti = 0.0, ti_prev = 0.0, to = 0.0, to_prev = 0.0;

  clk_buff dut (
    .iclk(iclk), .oclk(oclk), .irst_n(irst_n),
    .ien(ien), .oactive(oactive), .ocnt(ocnt)
  );

  clk_buff #(.SYNC_STAGES(2), .CNT_W(4)) u4 (
    .iclk(iclk), .oclk(oclk4), .irst_n(irst_n),
    .ien(ien), .oactive(oactive4), .ocnt(ocnt4)
  );

  always #(HALF) iclk = ~iclk;

  always @(posedge iclk) begin ti_prev = ti; ti = $realtime; end
  always @(posedge oclk) begin to_prev = to; to = $realtime; n_rise++; end

  always @(negedge oclk) begin
    if (irst_n === 1'b1 && $realtime > 0.0) begin
      n_checks++;
      assert (longint'(($realtime - to) * 1.0e6) == HALF_FS) n_pass++;
      else $error("FAIL pulse_width: observed %0d fs expected %0d fs",
                  longint'(($realtime - to) * 1.0e6), HALF_FS);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One iclk period. Checks the high phase, then drives ien (while iclk is
  // high) for the next edge, confirms the gate holds, then checks the low phase.
  task automatic cycle(input logic next_en);
    logic pulse;
    @(posedge iclk);
    pulse = m_gate;
    if (pulse) begin m_cnt++; m_pulses++; end
    m_edges++;
    m_gate = (m_edges >= SYNC) && m_en;
    #0.2;
    chk("oclk_high", {31'd0, oclk}, {31'd0, pulse});
    chk("oactive_high", {31'd0, oactive}, {31'd0, pulse});
    chk("ocnt", {16'd0, ocnt}, m_cnt & 32'hFFFF);
    chk("ocnt4", {28'd0, ocnt4}, m_cnt & 32'hF);
    ien  = next_en;
    m_en = next_en;
    #0.2;
    chk("gate_hold_oclk", {31'd0, oclk}, {31'd0, pulse});
    chk("gate_hold_oactive", {31'd0, oactive}, {31'd0, pulse});
    @(negedge iclk);
    #0.2;
    chk("oactive_low", {31'd0, oactive}, {31'd0, m_gate});
    chk("oclk_low", {31'd0, oclk}, 32'd0);
  endtask

  initial begin
    int   b_cnt, b_rise, guard;
    logic en;

    // Reset state
    #1.0;
    chk("rst_oclk", {31'd0, oclk}, 32'd0);
    chk("rst_oactive", {31'd0, oactive}, 32'd0);
    chk("rst_ocnt", {16'd0, ocnt}, 32'd0);
    chk("rst_ocnt4", {28'd0, ocnt4}, 32'd0);

    // Release at t=1.5 ns (low phase), ien held high
    #0.5;
    irst_n = 1'b1;
    cycle(1'b1);
    cycle(1'b1);
    chk("startup_oactive_before_edge3", {31'd0, oactive}, 32'd1);
    cycle(1'b1);
    chk("startup_first_rise_edge3", {31'd0, (to == ti) && (n_rise == 1)}, 32'd1);

    cycle(1'b1);
    chk("phase_diff_zero", {31'd0, to == ti}, 32'd1);
    chk("period_diff_zero", {31'd0, (to - to_prev) == (ti - ti_prev)}, 32'd1);
    chk("period_value", 32'(longint'((ti - ti_prev) * 1.0e6)), 32'(2 * HALF_FS));

    // ien low for 4 sampled edges
    b_cnt  = int'(ocnt);
    b_rise = n_rise;
    for (int i = 0; i < 4; i++) cycle(1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1);
    chk("disable4_ocnt_delta", 32'(int'(ocnt) - b_cnt), 32'd6);
    chk("disable4_rise_delta", 32'(n_rise - b_rise), 32'd6);

    // Random enables, toggled during the high phase
    for (int i = 0; i < 200; i++) begin
      en = ($urandom % 4) != 0;
      cycle(en);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1);

    // Reset asserted during an oclk high phase
    @(posedge iclk);
    if (m_gate) begin m_pulses++; end
    #0.3;
    irst_n = 1'b0;
    #0.001;
    chk("midrst_oclk", {31'd0, oclk}, 32'd0);
    chk("midrst_oactive", {31'd0, oactive}, 32'd0);
    chk("midrst_ocnt", {16'd0, ocnt}, 32'd0);
    chk("midrst_ocnt4", {28'd0, ocnt4}, 32'd0);
    m_gate = 1'b0; m_cnt = 0; m_edges = 0;
    ien = 1'b1; m_en = 1'b1;
    @(negedge iclk);
    #0.3;
    irst_n = 1'b1;

    // Startup repeats, then 17 active edges wrap the 4-bit counter to 1
    b_rise = n_rise;
    cycle(1'b1);
    cycle(1'b1);
    chk("restart_no_early_rise", 32'(n_rise - b_rise), 32'd0);
    cycle(1'b1);
    chk("restart_rise_edge3", {31'd0, (to == ti) && (n_rise - b_rise == 1)}, 32'd1);
    guard = 0;
    while (m_cnt < 17 && guard < 40) begin
      cycle(1'b1);
      guard++;
    end
    chk("wrap_budget", {31'd0, m_cnt == 17}, 32'd1);
    chk("wrap_ocnt4_is_1", {28'd0, ocnt4}, 32'd1);
    chk("wrap_ocnt_is_17", {16'd0, ocnt}, 32'd17);

    chk("total_oclk_rises", n_rise, m_pulses);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
